// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined CLA subtractor.
//   CLA_DATA_WID    default operand/result width
//   cla_stage_wid() width of one pipeline slice (half the operand width)
//   `CLA_SAT_MAX(W) / `CLA_SAT_MIN(W)
//                   signed saturation limits for a W-bit result. Used only
//                   when CLA_SUB_SATURATE_EN is defined.
`ifndef CLA_PKG_SV
`define CLA_PKG_SV

`define CLA_SAT_MAX(W) {1'b0, {((W)-1){1'b1}}}
`define CLA_SAT_MIN(W) {1'b1, {((W)-1){1'b0}}}

package cla_pkg;

  localparam int unsigned CLA_DATA_WID = 64;

  function automatic int unsigned cla_stage_wid(input int unsigned data_wid);
    return data_wid / 2;
  endfunction

endpackage

`endif

// File: rtl/cla_slice.sv
// Combinational carry-lookahead adder slice.
//   A, B      WID-bit addends
//   CarryIn   carry into bit 0
//   Sum       WID-bit sum
//   CarryOut  carry out of the top bit
// Each carry is built from the per-bit generate/propagate terms as a
// sum of products, so no carry depends on another carry.
module cla_slice #(
  parameter int unsigned WID = 32
) (
  input  logic [WID-1:0] A,
  input  logic [WID-1:0] B,
  input  logic           CarryIn,
  output logic [WID-1:0] Sum,
  output logic           CarryOut
);

  logic [WID-1:0] gen;
  logic [WID-1:0] prop;
  logic [WID:0]   carry;

  always_comb begin
    logic term;
    logic prop_run;
    gen      = A & B;
    prop     = A ^ B;
    carry    = '0;
    carry[0] = CarryIn;
    term     = 1'b0;
    prop_run = 1'b0;
    for (int unsigned i = 0; i < WID; i++) begin
      // carry[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]cin
      term     = gen[i];
      prop_run = prop[i];
      for (int unsigned j = 1; j <= i; j++) begin
        term     = term | (prop_run & gen[i-j]);
        prop_run = prop_run & prop[i-j];
      end
      carry[i+1] = term | (prop_run & CarryIn);
    end
    Sum      = prop ^ carry[WID-1:0];
    CarryOut = carry[WID];
  end

endmodule

// File: rtl/cla_pipe_subtractor.sv
// Two-stage pipelined subtractor: Difference = InputA - InputB - BorrowInput.
// The low half is resolved in stage 1. The registered inter-half carry
// feeds the high half in stage 2, which writes the output register.
// Ports:
//   Clock, Reset_n               clock, async active-low reset
//   InValid/InReady              operand handshake (InputA, InputB, BorrowInput)
//   OutValid/OutReady            result handshake
//   Difference                   result
//   BorrowOutput                 unsigned A < B + BorrowInput
//   Overflow                     signed overflow
//   Negative, Zero               sign and zero of Difference
// Optional: define CLA_SUB_SATURATE_EN to clamp Difference on signed
// overflow. Negative and Zero then follow the clamped value.
module cla_pipe_subtractor
  import cla_pkg::*;
#(
  parameter int unsigned DATA_WID = CLA_DATA_WID
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                InValid,
  output logic                InReady,
  input  logic [DATA_WID-1:0] InputA,
  input  logic [DATA_WID-1:0] InputB,
  input  logic                BorrowInput,
  output logic                OutValid,
  input  logic                OutReady,
  output logic [DATA_WID-1:0] Difference,
  output logic                BorrowOutput,
  output logic                Overflow,
  output logic                Negative,
  output logic                Zero
);

  localparam int unsigned STAGE_WID = cla_stage_wid(DATA_WID);

  logic                 s1_valid;
  logic [STAGE_WID-1:0] s1_diff_lo;
  logic                 s1_carry;
  logic [STAGE_WID-1:0] s1_a_hi;
  logic [STAGE_WID-1:0] s1_b_hi;
  logic                 s2_valid;

  logic                 advance;
  logic [STAGE_WID-1:0] b_lo_n;
  logic [STAGE_WID-1:0] b_hi_n;
  logic [STAGE_WID-1:0] lo_sum;
  logic                 lo_carry;
  logic [STAGE_WID-1:0] hi_sum;
  logic                 hi_carry;
  logic [DATA_WID-1:0]  raw_diff;
  logic [DATA_WID-1:0]  res_nxt;
  logic                 ovf_nxt;

  // S1 may load whenever it is empty or it is about to move into S2.
  assign advance  = ~s2_valid | OutReady;
  assign InReady  = ~s1_valid | advance;
  assign OutValid = s2_valid;

  // Subtraction as A + ~B + ~BorrowInput.
  assign b_lo_n = ~InputB[STAGE_WID-1:0];
  assign b_hi_n = ~s1_b_hi;

  cla_slice #(.WID(STAGE_WID)) u_slice_lo (
    .A        (InputA[STAGE_WID-1:0]),
    .B        (b_lo_n),
    .CarryIn  (~BorrowInput),
    .Sum      (lo_sum),
    .CarryOut (lo_carry)
  );

  cla_slice #(.WID(STAGE_WID)) u_slice_hi (
    .A        (s1_a_hi),
    .B        (b_hi_n),
    .CarryIn  (s1_carry),
    .Sum      (hi_sum),
    .CarryOut (hi_carry)
  );

  always_comb begin
    raw_diff = {hi_sum, s1_diff_lo};
    ovf_nxt  = (s1_a_hi[STAGE_WID-1] != s1_b_hi[STAGE_WID-1]) &&
               (raw_diff[DATA_WID-1] != s1_a_hi[STAGE_WID-1]);
    res_nxt  = raw_diff;
`ifdef CLA_SUB_SATURATE_EN
    if (ovf_nxt) begin
      res_nxt = s1_a_hi[STAGE_WID-1] ? `CLA_SAT_MIN(DATA_WID) : `CLA_SAT_MAX(DATA_WID);
    end
`endif
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid   <= 1'b0;
      s1_diff_lo <= '0;
      s1_carry   <= 1'b0;
      s1_a_hi    <= '0;
      s1_b_hi    <= '0;
    end else if (InReady) begin
      s1_valid <= InValid;
      if (InValid) begin
        s1_diff_lo <= lo_sum;
        s1_carry   <= lo_carry;
        s1_a_hi    <= InputA[DATA_WID-1:STAGE_WID];
        s1_b_hi    <= InputB[DATA_WID-1:STAGE_WID];
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      s2_valid     <= 1'b0;
      Difference   <= '0;
      BorrowOutput <= 1'b0;
      Overflow     <= 1'b0;
      Negative     <= 1'b0;
      Zero         <= 1'b0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        Difference   <= res_nxt;
        BorrowOutput <= ~hi_carry;
        Overflow     <= ovf_nxt;
        Negative     <= res_nxt[DATA_WID-1];
        Zero         <= (res_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_subtractor.sv
module tb_cla_pipe_subtractor;

  localparam int unsigned W = 64;

  logic         Clock = 1'b0;
  logic         Reset_n = 1'b0;
  logic         InValid = 1'b0;
  logic         InReady;
  logic [W-1:0] InputA = '0;
  logic [W-1:0] InputB = '0;
  logic         BorrowInput = 1'b0;
  logic         OutValid;
  logic         OutReady = 1'b0;
  logic [W-1:0] Difference;
  logic         BorrowOutput;
  logic         Overflow;
  logic         Negative;
  logic         Zero;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
    logic         neg;
    logic         zero;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    res_t         exp;
  } vec_t;

  res_t exp_q[$];
  res_t got_exp;
  int   checks = 0;
  int   failures = 0;
  int   outputs_seen = 0;

  always #5 Clock = ~Clock;

  cla_pipe_subtractor #(.DATA_WID(W)) dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .InValid      (InValid),
    .InReady      (InReady),
    .InputA       (InputA),
    .InputB       (InputB),
    .BorrowInput  (BorrowInput),
    .OutValid     (OutValid),
    .OutReady     (OutReady),
    .Difference   (Difference),
    .BorrowOutput (BorrowOutput),
    .Overflow     (Overflow),
    .Negative     (Negative),
    .Zero         (Zero)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference: true integer arithmetic on wide values.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    res_t                 r;
    logic signed [W+1:0]  sa, sb, sres, smax, smin;
    logic [W:0]           ub;
    ub   = {1'b0, b} + {{W{1'b0}}, bin};
    sa   = $signed({{2{a[W-1]}}, a});
    sb   = $signed({{2{b[W-1]}}, b});
    sres = sa - sb - $signed({{(W+1){1'b0}}, bin});
    smax = $signed({3'b000, {(W-1){1'b1}}});
    smin = -smax - 1;
    r.borrow = ({1'b0, a} < ub);
    r.ovf    = (sres > smax) || (sres < smin);
    r.diff   = sres[W-1:0];
`ifdef CLA_SUB_SATURATE_EN
    if (sres > smax) r.diff = smax[W-1:0];
    if (sres < smin) r.diff = smin[W-1:0];
`endif
    r.neg  = r.diff[W-1];
    r.zero = (r.diff == '0);
    return r;
  endfunction

  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                              input logic [W-1:0] d, input logic bo, input logic ov,
                              input logic ng, input logic zr);
    vec_t v;
    v.a = a; v.b = b; v.bin = bin;
    v.exp.diff = d; v.exp.borrow = bo; v.exp.ovf = ov; v.exp.neg = ng; v.exp.zero = zr;
    return v;
  endfunction

  // Output scoreboard: every output transfer must match the oldest accepted op.
  always @(negedge Clock) begin
    if (Reset_n && OutValid && OutReady) begin
      outputs_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=0x%0h required=no_output", Difference);
      end else begin
        got_exp = exp_q.pop_front();
        chk("difference", Difference, got_exp.diff);
        chk("flags_bovnz", W'({BorrowOutput, Overflow, Negative, Zero}),
            W'({got_exp.borrow, got_exp.ovf, got_exp.neg, got_exp.zero}));
      end
    end
  end

  // Present one op and hold it until accepted (bounded).
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                      input res_t e, input bit rand_ready);
    int unsigned waited;
    waited = 0;
    InputA = a; InputB = b; BorrowInput = bin; InValid = 1'b1;
    forever begin
      if (rand_ready) OutReady = ($urandom_range(3) != 0);
      @(negedge Clock);
      if (InReady) begin
        exp_q.push_back(e);
        @(posedge Clock); #1;
        break;
      end
      waited++;
      if (waited > 50) begin
        checks++;
        failures++;
        $display("FAIL send_timeout actual=InReady_low required=accept_within_50");
        @(posedge Clock); #1;
        break;
      end
      @(posedge Clock); #1;
    end
    InValid = 1'b0;
  endtask

  task automatic drain();
    OutReady = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge Clock); #1;
    end
    chk("drain_empty", W'(exp_q.size()), W'(0));
  endtask

  vec_t vecs[8];

  initial begin
    int acc;
    int base;
    logic [W-1:0] ra, rb;
    logic         rbin;

    vecs[0] = mk(64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[1] = mk(64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[2] = mk(64'd7, 64'd6, 1'b1, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    vecs[3] = mk(64'h0000_0001_0000_0000, 64'd1, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef CLA_SUB_SATURATE_EN
    vecs[4] = mk(64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
    vecs[5] = mk(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
`else
    vecs[4] = mk(64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[5] = mk(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b1, 1'b0);
`endif
    vecs[6] = mk(64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[7] = mk(64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset state
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    chk("rst_outvalid", W'(OutValid), W'(0));
    chk("rst_difference", Difference, '0);
    chk("rst_flags", W'({BorrowOutput, Overflow, Negative, Zero}), W'(0));
    Reset_n = 1'b1;
    @(posedge Clock); #1;
    chk("rst_inready", W'(InReady), W'(1));

    // Latency: accepting edge plus one more edge before OutValid
    OutReady = 1'b1;
    InputA = 64'd5; InputB = 64'd3; BorrowInput = 1'b0; InValid = 1'b1;
    @(negedge Clock);
    chk("lat_accept", W'(InReady), W'(1));
    exp_q.push_back(model(64'd5, 64'd3, 1'b0));
    @(posedge Clock); #1;
    InValid = 1'b0;
    @(negedge Clock);
    chk("lat_not_yet_valid", W'(OutValid), W'(0));
    @(posedge Clock); #1;
    @(negedge Clock);
    chk("lat_valid", W'(OutValid), W'(1));
    @(posedge Clock); #1;
    @(negedge Clock);
    chk("lat_single_output", W'(OutValid), W'(0));
    @(posedge Clock); #1;

    // Directed table, back-to-back
    for (int i = 0; i < 8; i++) send(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp, 1'b0);
    drain();

    // Backpressure: 4 ops, consumer stalled
    base = outputs_seen;
    OutReady = 1'b0;
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      InputA = W'(10 + acc); InputB = 64'd1; BorrowInput = 1'b0; InValid = 1'b1;
      @(negedge Clock);
      if (c >= 2) begin
        chk("bp_hold_valid", W'(OutValid), W'(1));
        chk("bp_hold_diff", Difference, 64'd9);
      end
      if (InReady) begin
        exp_q.push_back(model(W'(10 + acc), 64'd1, 1'b0));
        acc++;
      end
      @(posedge Clock); #1;
    end
    chk("bp_accepts", W'(acc), W'(2));
    chk("bp_inready_low", W'(InReady), W'(0));
    OutReady = 1'b1;
    while (acc < 4) begin
      send(W'(10 + acc), 64'd1, 1'b0, model(W'(10 + acc), 64'd1, 1'b0), 1'b0);
      acc++;
    end
    drain();
    chk("bp_output_count", W'(outputs_seen - base), W'(4));

    // Randomized stream with random backpressure
    for (int i = 0; i < 300; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      rbin = 1'($urandom_range(1));
      case ($urandom_range(7))
        0: rb = ra;
        1: ra[W-1:W/2] = rb[W-1:W/2];
        2: rb[W/2-1:0] = ra[W/2-1:0];
        default: ;
      endcase
      send(ra, rb, rbin, model(ra, rb, rbin), 1'b1);
    end
    drain();

    // Reset mid-flight: two ops held in the pipe
    OutReady = 1'b0;
    send(64'd100, 64'd1, 1'b0, model(64'd100, 64'd1, 1'b0), 1'b0);
    send(64'd200, 64'd1, 1'b0, model(64'd200, 64'd1, 1'b0), 1'b0);
    @(negedge Clock);
    chk("mid_pre_valid", W'(OutValid), W'(1));
    #2;
    Reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_outvalid", W'(OutValid), W'(0));
    chk("mid_rst_difference", Difference, '0);
    chk("mid_rst_flags", W'({BorrowOutput, Overflow, Negative, Zero}), W'(0));
    @(posedge Clock); #3;
    Reset_n = 1'b1;
    @(posedge Clock); #1;
    chk("mid_post_inready", W'(InReady), W'(1));
    base = outputs_seen;
    OutReady = 1'b1;
    repeat (6) @(posedge Clock);
    #1;
    chk("mid_no_stale_output", W'(outputs_seen - base), W'(0));

    // Pipe still works after reset
    send(64'd5, 64'd3, 1'b0, model(64'd5, 64'd3, 1'b0), 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
